// File: rtl/psum_drain_pkg.sv
// psum_drain_pkg: shared types and helpers for the partial-sum drain path
package psum_drain_pkg;
    typedef enum logic {IDLE, DRAIN} drain_state_t;
    function automatic int idx_w(input int rows);
        return $clog2(rows);
    endfunction
endpackage

// File: rtl/psum_drain_if.sv
// psum_drain_if: capture request, packed partial sums and the valid/ready result stream
interface psum_drain_if
    import psum_drain_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ROWS   = 4,
    parameter int OWIDTH = 16
);
    localparam int IW = idx_w(ROWS);
    logic                    i_capture;
    logic [ROWS*WIDTH-1:0]   i_psum;
    logic                    i_clr_err;
    logic                    i_ready;
    logic                    o_valid;
    logic [OWIDTH-1:0]       o_data;
    logic [IW-1:0]           o_row;
    logic                    o_last;
    logic                    o_sat;
    logic                    o_busy;
    logic                    o_overrun;
    modport slave (
        input  i_capture, i_psum, i_clr_err, i_ready,
        output o_valid, o_data, o_row, o_last, o_sat, o_busy, o_overrun
    );
    modport master (
        output i_capture, i_psum, i_clr_err, i_ready,
        input  o_valid, o_data, o_row, o_last, o_sat, o_busy, o_overrun
    );
endinterface

// File: rtl/psum_drain_shift_sat.sv
// shift_sat: arithmetic right shift followed by signed saturation to OWIDTH
module shift_sat #(
    parameter int WIDTH  = 32,
    parameter int OWIDTH = 16,
    parameter int SHIFT  = 0
) (
    input  logic signed [WIDTH-1:0]  val_i,
    output logic signed [OWIDTH-1:0] val_o,
    output logic                     sat_o
);
    localparam logic signed [WIDTH-1:0] MAX_W = {{(WIDTH-OWIDTH+1){1'b0}}, {(OWIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MIN_W = {{(WIDTH-OWIDTH+1){1'b1}}, {(OWIDTH-1){1'b0}}};
    logic signed [WIDTH-1:0] s;
    logic hi, lo;
    always_comb begin
        s     = val_i >>> SHIFT;
        hi    = s > MAX_W;
        lo    = s < MIN_W;
        sat_o = hi | lo;
        val_o = hi ? {1'b0, {(OWIDTH-1){1'b1}}} : lo ? {1'b1, {(OWIDTH-1){1'b0}}} : s[OWIDTH-1:0];
    end
endmodule

// File: rtl/psum_drain.sv
// psum_drain: snapshots ROWS accumulator values on capture and streams them
// out one per beat, scaled and saturated, over valid/ready
module psum_drain
    import psum_drain_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ROWS   = 4,
    parameter int OWIDTH = 16,
    parameter int SHIFT  = 0
) (
    input logic         clk,
    input logic         rst,
    psum_drain_if.slave bus
);
    localparam int IW = idx_w(ROWS);
    drain_state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic ovr_q, ovr_d;
    logic signed [WIDTH-1:0] shadow_q [ROWS];
    logic load, hs, last, valid, sat;
    logic signed [OWIDTH-1:0] data;

    shift_sat #(.WIDTH(WIDTH), .OWIDTH(OWIDTH), .SHIFT(SHIFT)) u_shift_sat (
        .val_i (shadow_q[idx_q]),
        .val_o (data),
        .sat_o (sat)
    );

    always_comb begin
        valid   = state_q == DRAIN;
        last    = idx_q == IW'(ROWS-1);
        hs      = valid & bus.i_ready;
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        if (!valid) begin
            load    = bus.i_capture;
            state_d = bus.i_capture ? DRAIN : IDLE;
            idx_d   = bus.i_capture ? '0 : idx_q;
        end else if (hs) begin
            load    = last & bus.i_capture;
            state_d = (last & !bus.i_capture) ? IDLE : DRAIN;
            idx_d   = last ? '0 : idx_q + 1'b1;
        end
        // a capture is dropped unless it lands in IDLE or on the final handshake
        ovr_d = (valid & bus.i_capture & !(hs & last)) | (ovr_q & !bus.i_clr_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ovr_q   <= 1'b0;
            for (int r = 0; r < ROWS; r++) shadow_q[r] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ovr_q   <= ovr_d;
            if (load) for (int r = 0; r < ROWS; r++) shadow_q[r] <= bus.i_psum[r*WIDTH +: WIDTH];
        end
    end

    assign bus.o_valid   = valid;
    assign bus.o_busy    = valid;
    assign bus.o_data    = valid ? data : '0;
    assign bus.o_sat     = valid & sat;
    assign bus.o_row     = valid ? idx_q : '0;
    assign bus.o_last    = valid & last;
    assign bus.o_overrun = ovr_q;
endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: directed vectors against two drains (SHIFT=0 and SHIFT=4) sharing one stimulus
module tb_psum_drain;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cap = 1'b0, clr = 1'b0, rdy = 1'b0;
    logic [127:0] psum = '0;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    psum_drain_if #(.WIDTH(32), .ROWS(4), .OWIDTH(16)) b0 ();
    psum_drain_if #(.WIDTH(32), .ROWS(4), .OWIDTH(16)) b4 ();

    assign b0.i_capture = cap;
    assign b0.i_psum    = psum;
    assign b0.i_clr_err = clr;
    assign b0.i_ready   = rdy;
    assign b4.i_capture = cap;
    assign b4.i_psum    = psum;
    assign b4.i_clr_err = clr;
    assign b4.i_ready   = rdy;

    psum_drain #(.WIDTH(32), .ROWS(4), .OWIDTH(16), .SHIFT(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
    psum_drain #(.WIDTH(32), .ROWS(4), .OWIDTH(16), .SHIFT(4)) u4 (.clk(clk), .rst(rst), .bus(b4));

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] pk(input int a, input int b, input int c, input int d);
        return {d, c, b, a};
    endfunction

    task automatic beat(input string tag, input int d, input int r, input int l, input int s);
        chk({tag, ".valid"}, int'(b0.o_valid), 1);
        chk({tag, ".busy"}, int'(b0.o_busy), 1);
        chk({tag, ".data"}, int'($signed(b0.o_data)), d);
        chk({tag, ".row"}, int'(b0.o_row), r);
        chk({tag, ".last"}, int'(b0.o_last), l);
        chk({tag, ".sat"}, int'(b0.o_sat), s);
    endtask

    task automatic idle(input string tag);
        chk({tag, ".valid"}, int'(b0.o_valid), 0);
        chk({tag, ".busy"}, int'(b0.o_busy), 0);
    endtask

    initial begin
        // reset with random inputs, capture held high
        rst = 1'b1;
        cap = 1'b1;
        for (int i = 0; i < 2; i++) begin
            psum = {$urandom, $urandom, $urandom, $urandom};
            clr  = 1'($urandom);
            rdy  = 1'($urandom);
            tick();
            idle("rst");
            chk("rst.data", int'(b0.o_data), 0);
            chk("rst.row", int'(b0.o_row), 0);
            chk("rst.last", int'(b0.o_last), 0);
            chk("rst.sat", int'(b0.o_sat), 0);
            chk("rst.ovr", int'(b0.o_overrun), 0);
        end
        rst = 1'b0;
        cap = 1'b0;
        clr = 1'b0;
        rdy = 1'b1;
        tick();
        idle("post_rst");

        // plain drain, latency 1
        psum = pk(5, -3, 100, 0);
        cap  = 1'b1;
        tick();
        cap  = 1'b0;
        psum = pk(7, 7, 7, 7);
        beat("d0", 5, 0, 0, 0);
        tick();
        beat("d1", -3, 1, 0, 0);
        tick();
        beat("d2", 100, 2, 0, 0);
        tick();
        beat("d3", 0, 3, 1, 0);
        tick();
        idle("d_end");

        // backpressure on row 1
        psum = pk(5, -3, 100, 0);
        cap  = 1'b1;
        tick();
        cap = 1'b0;
        beat("bp0", 5, 0, 0, 0);
        tick();
        rdy = 1'b0;
        beat("bp1a", -3, 1, 0, 0);
        tick();
        beat("bp1b", -3, 1, 0, 0);
        tick();
        beat("bp1c", -3, 1, 0, 0);
        rdy = 1'b1;
        tick();
        beat("bp2", 100, 2, 0, 0);
        tick();
        beat("bp3", 0, 3, 1, 0);
        tick();
        idle("bp_end");

        // saturation, and the SHIFT=4 instance on the same data
        psum = pk(40000, -40000, 32767, -32768);
        cap  = 1'b1;
        tick();
        cap = 1'b0;
        beat("s0", 32767, 0, 0, 1);
        chk("s4_0.data", int'($signed(b4.o_data)), 2500);
        chk("s4_0.sat", int'(b4.o_sat), 0);
        tick();
        beat("s1", -32768, 1, 0, 1);
        chk("s4_1.data", int'($signed(b4.o_data)), -2500);
        tick();
        beat("s2", 32767, 2, 0, 0);
        chk("s4_2.data", int'($signed(b4.o_data)), 2047);
        tick();
        beat("s3", -32768, 3, 1, 0);
        chk("s4_3.data", int'($signed(b4.o_data)), -2048);
        tick();
        idle("s_end");

        // capture mid-drain is dropped and flagged
        psum = pk(1, 2, 3, 4);
        cap  = 1'b1;
        tick();
        cap = 1'b0;
        beat("o0", 1, 0, 0, 0);
        tick();
        beat("o1", 2, 1, 0, 0);
        chk("o1.ovr", int'(b0.o_overrun), 0);
        cap  = 1'b1;
        psum = pk(9, 9, 9, 9);
        tick();
        cap = 1'b0;
        beat("o2", 3, 2, 0, 0);
        chk("o2.ovr", int'(b0.o_overrun), 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        beat("o3", 4, 3, 1, 0);
        chk("o3.ovr", int'(b0.o_overrun), 0);
        // capture on the final handshake chains without a bubble
        cap  = 1'b1;
        psum = pk(11, 12, 13, 14);
        tick();
        cap = 1'b0;
        beat("c0", 11, 0, 0, 0);
        chk("c0.ovr", int'(b0.o_overrun), 0);
        tick();
        beat("c1", 12, 1, 0, 0);
        tick();
        beat("c2", 13, 2, 0, 0);
        tick();
        beat("c3", 14, 3, 1, 0);
        tick();
        idle("c_end");

        // reset mid-drain with the overrun flag set
        psum = pk(21, 22, 23, 24);
        cap  = 1'b1;
        tick();
        beat("r0", 21, 0, 0, 0);
        tick();
        cap = 1'b0;
        beat("r1", 22, 1, 0, 0);
        tick();
        beat("r2", 23, 2, 0, 0);
        chk("r2.ovr", int'(b0.o_overrun), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle("r_rst");
        chk("r_rst.ovr", int'(b0.o_overrun), 0);
        chk("r_rst.row", int'(b0.o_row), 0);
        psum = pk(31, 32, 33, 34);
        cap  = 1'b1;
        tick();
        cap = 1'b0;
        beat("f0", 31, 0, 0, 0);
        tick();
        beat("f1", 32, 1, 0, 0);
        tick();
        beat("f2", 33, 2, 0, 0);
        tick();
        beat("f3", 34, 3, 1, 0);
        tick();
        idle("f_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
